pc_sequencer: RTL and testbench

Sequential next-PC controller for the CPU fetch stage. It owns the program counter and consumes the 2-bit PC-source code from the jump/branch control block (00 sequential, 01 branch target, 10 jump target, 11 jump register). It applies that code to advance or redirect the PC, inserts a programmable number of flush bubbles after every taken redirect, and supports stall and halt. It also captures a link address for jal/jalr and counts taken redirects.

---
 rtl/pc_sequencer_if.sv | 29 ++
 rtl/pc_sequencer.sv | 112 +++++++++++
 tb/tb_pc_sequencer.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
// Fetch-control bus between the decode/branch logic and the PC sequencer.
// The master drives redirect requests and the slave reports PC and fetch status.
interface pc_sequencer_if #(
    parameter int CNT_W = 16
);
    logic [1:0]       jbout;
    logic             instr_valid;
    logic [31:0]      br_target;
    logic [31:0]      j_target;
    logic [31:0]      jr_target;
    logic             stall;
    logic             halt;
    logic [31:0]      pc;
    logic             fetch_valid;
    logic             flush;
    logic [31:0]      link_addr;
    logic             halted;
    logic [CNT_W-1:0] redirect_cnt;

    modport master (
        output jbout, instr_valid, br_target, j_target, jr_target, stall, halt,
        input  pc, fetch_valid, flush, link_addr, halted, redirect_cnt
    );

    modport slave (
        input  jbout, instr_valid, br_target, j_target, jr_target, stall, halt,
        output pc, fetch_valid, flush, link_addr, halted, redirect_cnt
    );
endinterface

// File: rtl/pc_sequencer.sv
// Next-PC sequencer for the fetch stage: sequential advance, redirects with a
// programmable flush window, stall and halt, link capture and a redirect counter.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          FLUSH_CYCLES = 1,
    parameter int          CNT_W        = 16
) (
    input logic           clk,
    input logic           reset_n,
    pc_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_FLUSH = 2'd1,
        S_HALT  = 2'd2
    } state_e;

    localparam logic [2:0] FLUSH_LD = 3'(FLUSH_CYCLES);

    state_e           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      link_q, link_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       fcnt_q, fcnt_d;
    logic [31:0]      target;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end
        return v + CNT_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        assert (FLUSH_CYCLES >= 1 && FLUSH_CYCLES <= 7)
        else $error("pc_sequencer: FLUSH_CYCLES=%0d outside 1..7", FLUSH_CYCLES);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_RUN;
            pc_q    <= RESET_PC;
            link_q  <= 32'h0;
            cnt_q   <= '0;
            fcnt_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            link_q  <= link_d;
            cnt_q   <= cnt_d;
            fcnt_q  <= fcnt_d;
        end
    end

    always_comb begin
        case (bus.jbout)
            2'b01:   target = bus.br_target;
            2'b10:   target = bus.j_target;
            default: target = bus.jr_target;
        endcase
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        link_d  = link_q;
        cnt_d   = cnt_q;
        fcnt_d  = fcnt_q;
        case (state_q)
            S_RUN: begin
                if (bus.halt) begin
                    state_d = S_HALT;
                end else if (bus.stall) begin
                    state_d = S_RUN;
                end else if (bus.instr_valid && bus.jbout != 2'b00) begin
                    pc_d    = {target[31:2], 2'b00};
                    link_d  = pc_q;
                    cnt_d   = sat_inc(cnt_q);
                    fcnt_d  = FLUSH_LD;
                    state_d = S_FLUSH;
                end else begin
                    pc_d = pc_q + 32'd4;
                end
            end
            S_FLUSH: begin
                if (bus.halt) begin
                    state_d = S_HALT;
                end else if (bus.stall) begin
                    state_d = S_FLUSH;
                end else if (fcnt_q == 3'd1) begin
                    state_d = S_RUN;
                end else begin
                    fcnt_d = fcnt_q - 3'd1;
                end
            end
            // HALT is left only through reset
            S_HALT:  state_d = S_HALT;
            default: state_d = S_RUN;
        endcase
    end

    always_comb begin
        bus.fetch_valid  = (state_q == S_RUN) && !bus.stall;
        bus.flush        = (state_q == S_FLUSH);
        bus.halted       = (state_q == S_HALT);
        bus.pc           = pc_q;
        bus.link_addr    = link_q;
        bus.redirect_cnt = cnt_q;
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: one default instance and one with a wrapping
// reset PC, a 3-cycle flush window and a 2-bit redirect counter.
module tb_pc_sequencer;

    logic clk = 1'b0;
    logic rn_a, rn_b;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    pc_sequencer_if #(.CNT_W(16)) ia ();
    pc_sequencer_if #(.CNT_W(2))  ib ();

    pc_sequencer #(
        .RESET_PC(32'h0000_0000), .FLUSH_CYCLES(1), .CNT_W(16)
    ) u_a (
        .clk(clk), .reset_n(rn_a), .bus(ia.slave)
    );

    pc_sequencer #(
        .RESET_PC(32'hFFFF_FFF8), .FLUSH_CYCLES(3), .CNT_W(2)
    ) u_b (
        .clk(clk), .reset_n(rn_b), .bus(ib.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rn_a = 1'b0;
        rn_b = 1'b0;
        ia.jbout = 2'b00; ia.instr_valid = 1'b0; ia.stall = 1'b0; ia.halt = 1'b0;
        ia.br_target = 32'h0; ia.j_target = 32'h0; ia.jr_target = 32'h0;
        ib.jbout = 2'b00; ib.instr_valid = 1'b0; ib.stall = 1'b0; ib.halt = 1'b0;
        ib.br_target = 32'h0; ib.j_target = 32'h0; ib.jr_target = 32'h0;

        // reset held for two edges
        step();
        step();
        chk("a_rst_pc",    ia.pc, 32'h0);
        chk("a_rst_fv",    32'(ia.fetch_valid), 32'd1);
        chk("a_rst_flush", 32'(ia.flush), 32'd0);
        chk("a_rst_halt",  32'(ia.halted), 32'd0);
        chk("a_rst_link",  ia.link_addr, 32'h0);
        chk("a_rst_cnt",   32'(ia.redirect_cnt), 32'd0);
        rn_a = 1'b1;

        step(); chk("a_seq_4", ia.pc, 32'h4);
        step(); chk("a_seq_8", ia.pc, 32'h8);
        step(); chk("a_seq_c", ia.pc, 32'hC);
        chk("a_seq_fv", 32'(ia.fetch_valid), 32'd1);
        step(); chk("a_seq_10", ia.pc, 32'h10);

        // branch redirect with a single flush bubble
        ia.instr_valid = 1'b1; ia.jbout = 2'b01; ia.br_target = 32'h0000_0103;
        step();
        ia.instr_valid = 1'b0; ia.jbout = 2'b00;
        chk("a_br_pc",    ia.pc, 32'h100);
        chk("a_br_flush", 32'(ia.flush), 32'd1);
        chk("a_br_fv",    32'(ia.fetch_valid), 32'd0);
        chk("a_br_link",  ia.link_addr, 32'h10);
        chk("a_br_cnt",   32'(ia.redirect_cnt), 32'd1);
        step();
        chk("a_br_pc_hold", ia.pc, 32'h100);
        chk("a_br_flush0",  32'(ia.flush), 32'd0);
        chk("a_br_fv1",     32'(ia.fetch_valid), 32'd1);
        step();
        chk("a_br_pc104", ia.pc, 32'h104);

        // stall wins over a jump presented in the same cycle
        ia.stall = 1'b1; ia.instr_valid = 1'b1; ia.jbout = 2'b10; ia.j_target = 32'h208;
        #1;
        chk("a_stall_fv", 32'(ia.fetch_valid), 32'd0);
        step();
        chk("a_stall_pc",  ia.pc, 32'h104);
        chk("a_stall_cnt", 32'(ia.redirect_cnt), 32'd1);
        ia.stall = 1'b0;
        #1;
        chk("a_unstall_fv", 32'(ia.fetch_valid), 32'd1);
        step();
        ia.instr_valid = 1'b0; ia.jbout = 2'b00;
        chk("a_jmp_pc",    ia.pc, 32'h208);
        chk("a_jmp_cnt",   32'(ia.redirect_cnt), 32'd2);
        chk("a_jmp_link",  ia.link_addr, 32'h104);
        chk("a_jmp_flush", 32'(ia.flush), 32'd1);
        step();
        step();
        chk("a_jmp_pc20c", ia.pc, 32'h20C);

        // instance B: wrap around the top of the address space
        chk("b_rst_pc", ib.pc, 32'hFFFF_FFF8);
        rn_b = 1'b1;
        step(); chk("b_wrap_fffc", ib.pc, 32'hFFFF_FFFC);
        step(); chk("b_wrap_0",    ib.pc, 32'h0);
        step(); chk("b_wrap_4",    ib.pc, 32'h4);

        // jump-register redirect, 3 bubbles stretched to 5 by a 2-cycle stall
        ib.instr_valid = 1'b1; ib.jbout = 2'b11; ib.jr_target = 32'h401;
        step();
        ib.instr_valid = 1'b0; ib.jbout = 2'b00;
        chk("b_jr_pc",  ib.pc, 32'h400);
        chk("b_jr_link", ib.link_addr, 32'h4);
        chk("b_jr_fl1", 32'(ib.flush), 32'd1);
        step(); chk("b_jr_fl2", 32'(ib.flush), 32'd1);
        ib.stall = 1'b1;
        step(); chk("b_jr_fl3", 32'(ib.flush), 32'd1);
        step(); chk("b_jr_fl4", 32'(ib.flush), 32'd1);
        chk("b_jr_pc_stall", ib.pc, 32'h400);
        ib.stall = 1'b0;
        step(); chk("b_jr_fl5", 32'(ib.flush), 32'd1);
        step();
        chk("b_jr_fl_end", 32'(ib.flush), 32'd0);
        chk("b_jr_fv",     32'(ib.fetch_valid), 32'd1);
        chk("b_jr_pc400",  ib.pc, 32'h400);
        step(); chk("b_jr_pc404", ib.pc, 32'h404);

        // four more redirects drive the 2-bit counter into saturation
        for (int k = 0; k < 4; k++) begin
            ib.instr_valid = 1'b1; ib.jbout = 2'b01; ib.br_target = 32'h800;
            step();
            ib.instr_valid = 1'b0; ib.jbout = 2'b00;
            chk("b_sat_pc", ib.pc, 32'h800);
            if (k == 0) chk("b_sat_cnt2", 32'(ib.redirect_cnt), 32'd2);
            step(); step(); step();
        end
        chk("b_sat_cnt3", 32'(ib.redirect_cnt), 32'd3);
        chk("b_sat_link", ib.link_addr, 32'h800);

        // halt during FLUSH freezes everything until reset
        ib.instr_valid = 1'b1; ib.jbout = 2'b10; ib.j_target = 32'hC00;
        step();
        chk("b_hj_pc",  ib.pc, 32'hC00);
        chk("b_hj_cnt", 32'(ib.redirect_cnt), 32'd3);
        ib.instr_valid = 1'b0; ib.jbout = 2'b00; ib.halt = 1'b1;
        step();
        ib.halt = 1'b0;
        chk("b_halted",   32'(ib.halted), 32'd1);
        chk("b_halt_fl",  32'(ib.flush), 32'd0);
        chk("b_halt_fv",  32'(ib.fetch_valid), 32'd0);
        for (int k = 0; k < 10; k++) begin
            ib.instr_valid = 1'b1;
            ib.jbout = k[1:0];
            ib.br_target = 32'h1000 + 32'(k);
            step();
            chk("b_halt_pc",  ib.pc, 32'hC00);
            chk("b_halt_hd",  32'(ib.halted), 32'd1);
        end
        chk("b_halt_link", ib.link_addr, 32'h800);
        ib.instr_valid = 1'b0; ib.jbout = 2'b00;
        rn_b = 1'b0;
        step();
        rn_b = 1'b1;
        chk("b_rst2_pc",   ib.pc, 32'hFFFF_FFF8);
        chk("b_rst2_hd",   32'(ib.halted), 32'd0);
        chk("b_rst2_cnt",  32'(ib.redirect_cnt), 32'd0);
        chk("b_rst2_link", ib.link_addr, 32'h0);
        chk("b_rst2_fv",   32'(ib.fetch_valid), 32'd1);
        step();
        chk("b_rst2_seq", ib.pc, 32'hFFFF_FFFC);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
